// File: rtl/nanorv32_ahb_console.sv
// AHB-lite console FIFO and test-result responder for the nanorv32 data bus.
// Build option: define NANORV32_CONSOLE_LINEBUF_EN to release console bytes a line at a time.
module nanorv32_ahb_console #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] PASS_CODE  = 32'hCAFFE000,
  parameter logic [31:0] FAIL_CODE  = 32'hDEADD000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic [31:0]       hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              test_pass,
  output logic              test_fail
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned RegW = ADDR_W - 2;

  localparam logic [RegW-1:0] RegData   = RegW'(0);
  localparam logic [RegW-1:0] RegStatus = RegW'(1);
  localparam logic [RegW-1:0] RegResult = RegW'(2);
  localparam logic [RegW-1:0] RegCtrl   = RegW'(3);

  typedef logic [PtrW:0] ptr_t;

  logic            dp_valid_q, dp_write_q;
  logic [RegW-1:0] dp_reg_q;
  ptr_t            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, nl_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [31:0]     result_q, result_d, hrdata_q, rdata_d;
  logic            pass_q, pass_d, fail_q, fail_d;
  logic            empty, full, pop, push, stall, flush, wr_data, wr_result, addr_cap;
  logic            unused_bits;

  function automatic logic is_full(ptr_t wr, ptr_t rd);
    return (wr[PtrW] != rd[PtrW]) && (wr[PtrW-1:0] == rd[PtrW-1:0]);
  endfunction

  function automatic logic [31:0] status_word(ptr_t wr, ptr_t rd, ptr_t nl, logic p, logic f);
    ptr_t        lvl;
    logic [31:0] lvl32, nl32, s;
    lvl      = wr - rd;
    lvl32    = 32'(lvl);
    nl32     = 32'(nl);
    s        = '0;
    s[0]     = (wr == rd);
    s[1]     = is_full(wr, rd);
    s[2]     = p;
    s[3]     = f;
    s[15:8]  = lvl32[7:0];
    s[23:16] = nl32[7:0];
    return s;
  endfunction

  assign unused_bits = ^{hsize, haddr[1:0]};

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = is_full(wr_ptr_q, rd_ptr_q);
  assign tx_data   = mem_q[rd_ptr_q[PtrW-1:0]];
  assign pop       = tx_valid & tx_ready;
  assign addr_cap  = hsel & htrans[1] & hready;
  assign wr_data   = dp_valid_q & dp_write_q & (dp_reg_q == RegData);
  assign wr_result = dp_valid_q & dp_write_q & (dp_reg_q == RegResult);
  assign flush     = dp_valid_q & dp_write_q & (dp_reg_q == RegCtrl) & hwdata[0];
  // A pop in the same cycle frees the slot, so a full FIFO only stalls without one.
  assign stall     = wr_data & full & ~pop;
  assign push      = wr_data & ~stall;
  assign hreadyout = ~stall;
  assign hresp     = 1'b0;
  assign hrdata    = hrdata_q;
  assign test_pass = pass_q;
  assign test_fail = fail_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    result_d = wr_result ? hwdata : result_q;
    pass_d   = pass_q | (wr_result & (hwdata == PASS_CODE));
    fail_d   = fail_q | (wr_result & (hwdata == FAIL_CODE));
    // Read data is taken from next-state so a read issued behind a write sees its effect.
    rdata_d  = '0;
    if (addr_cap && !hwrite) begin
      case (haddr[ADDR_W-1:2])
        RegStatus: rdata_d = status_word(wr_ptr_d, rd_ptr_d, nl_d, pass_d, fail_d);
        RegResult: rdata_d = result_d;
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_reg_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      result_q   <= '0;
      hrdata_q   <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      if (hready) begin
        dp_valid_q <= addr_cap;
        dp_write_q <= hwrite;
        dp_reg_q   <= haddr[ADDR_W-1:2];
        hrdata_q   <= rdata_d;
      end else if (!stall) begin
        dp_valid_q <= 1'b0;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      result_q <= result_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= hwdata[7:0];
    end
  end

`ifdef NANORV32_CONSOLE_LINEBUF_EN
  ptr_t nl_q;

  always_comb begin
    nl_d = nl_q;
    if (flush) begin
      nl_d = '0;
    end else begin
      if (push && hwdata[7:0] == 8'h0A) nl_d = nl_d + ptr_t'(1);
      if (pop && tx_data == 8'h0A)      nl_d = nl_d - ptr_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) nl_q <= '0;
    else     nl_q <= nl_d;
  end

  // A full FIFO must drain even without a newline, or the CPU would stall forever.
  assign tx_valid = ~empty & ((nl_q != '0) | full);
`else
  assign nl_d     = '0;
  assign tx_valid = ~empty;
`endif

endmodule

// File: tb/tb_nanorv32_ahb_console.sv
// Bench for nanorv32_ahb_console: scoreboarded console stream, table-driven register accesses
// and hand-written stall, flush and reset sequences. Line mode is covered when built with
// NANORV32_CONSOLE_LINEBUF_EN.
module tb_nanorv32_ahb_console;
  localparam int unsigned ADDR_W = 5;
`ifdef NANORV32_CONSOLE_LINEBUF_EN
  localparam logic [31:0] NlOne = 32'h0001_0000;
`else
  localparam logic [31:0] NlOne = 32'h0;
`endif

  logic              clk = 1'b0;
  logic              rst, hsel, hwrite, hready, hreadyout, hresp, tx_valid, tx_ready;
  logic              test_pass, test_fail;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [31:0]       hwdata, hrdata;
  logic [7:0]        tx_data, mon_b;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    bit              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]     wdata;
    logic [31:0]     exp_rdata;
    bit              exp_pass;
    bit              exp_fail;
  } vec_t;

  vec_t tbl [13];

  // Single responder on the bus, so the bus-wide ready is our own.
  assign hready = hreadyout;

  always #5 clk = ~clk;

  nanorv32_ahb_console #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (8),
    .PASS_CODE  (32'hCAFFE000),
    .FAIL_CODE  (32'hDEADD000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hwdata    (hwdata),
    .hready    (hready),
    .hrdata    (hrdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .test_pass (test_pass),
    .test_fail (test_fail)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic ahb_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    int waited;
    hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = data;
    if (addr[ADDR_W-1:2] == 3'd0) exp_q.push_back(data[7:0]);
    waited = 0;
    while (!hreadyout && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!hreadyout) check("write_timeout", 32'(hreadyout), 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic ahb_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data);
    hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    data = hrdata;
    @(posedge clk); #1;
  endtask

  // Scoreboard: every byte accepted by the sink must match the oldest byte written.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected: got 0x%02h, expected no byte", tx_data);
      end else begin
        mon_b = exp_q.pop_front();
        check("tx_byte", 32'(tx_data), 32'(mon_b));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  ord [3];

    rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hwdata = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hreadyout", 32'(hreadyout), 32'h1);
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_hresp", 32'(hresp), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_pass", 32'(test_pass), 32'h0);
    check("rst_fail", 32'(test_fail), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    ahb_read(5'h04, rd);
    check("rst_status", rd, 32'h1);

`ifdef NANORV32_CONSOLE_LINEBUF_EN
    ahb_write(5'h00, 32'h61);
    check("lb_hold_a", 32'(tx_valid), 32'h0);
    ahb_write(5'h00, 32'h62);
    check("lb_hold_b", 32'(tx_valid), 32'h0);
    ahb_write(5'h00, 32'h0A);
    check("lb_release", 32'(tx_valid), 32'h1);
    ahb_read(5'h04, rd);
    check("lb_status", rd, 32'h0001_0300);
    tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("lb_drain_valid", 32'(tx_valid), 32'h1);
      @(posedge clk); #1;
    end
    check("lb_drained", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    ahb_read(5'h04, rd);
    check("lb_status_empty", rd, 32'h1);
`else
    ord[0] = 8'h48; ord[1] = 8'h69; ord[2] = 8'h0A;
    tx_ready = 1'b1;
    ahb_write(5'h00, 32'h48);
    check("first_valid", 32'(tx_valid), 32'h1);
    check("first_data", 32'(tx_data), 32'h48);
    tx_ready = 1'b0;
    ahb_write(5'h00, 32'h69);
    ahb_write(5'h00, 32'h0A);
    tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("order_valid", 32'(tx_valid), 32'h1);
      check("order_data", 32'(tx_data), 32'(ord[k]));
      @(posedge clk); #1;
    end
    check("order_drained", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
`endif

    // Fill the FIFO, then a ninth write must stall until one pop.
    for (int i = 0; i < 8; i++) ahb_write(5'h00, 32'h10 + 32'(i));
    check("full_valid", 32'(tx_valid), 32'h1);
    ahb_read(5'h04, rd);
    check("full_status", rd, 32'h0000_0802);
    hsel = 1'b1; haddr = 5'h00; htrans = 2'b10; hwrite = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0A;
    exp_q.push_back(8'h0A);
    check("stall_hreadyout", 32'(hreadyout), 32'h0);
    @(posedge clk); #1;
    check("stall_held", 32'(hreadyout), 32'h0);
    check("stall_head", 32'(tx_data), 32'h10);
    tx_ready = 1'b1;
    #1;
    check("stall_release", 32'(hreadyout), 32'h1);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("stall_new_head", 32'(tx_data), 32'h11);
    ahb_read(5'h04, rd);
    check("stall_status", rd, 32'h0000_0802 | NlOne);
    tx_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    check("full_drained", 32'(tx_valid), 32'h0);
    ahb_read(5'h04, rd);
    check("full_status_empty", rd, 32'h1);

    // Flush with the STATUS read issued right behind the CTRL write.
    for (int i = 0; i < 5; i++) ahb_write(5'h00, 32'h20 + 32'(i));
    ahb_read(5'h04, rd);
    check("flush_pre_status", rd, 32'h0000_0500);
    hsel = 1'b1; haddr = 5'h0C; htrans = 2'b10; hwrite = 1'b1;
    @(posedge clk); #1;
    hwdata = 32'h1; haddr = 5'h04; hwrite = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    check("flush_status", hrdata, 32'h1);
    exp_q.delete();
    @(posedge clk); #1;
    check("flush_tx_valid", 32'(tx_valid), 32'h0);

    tbl[0]  = '{1'b1, 5'h10, 32'hCAFFE000, 32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'h10, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'h08, 32'hDEADD000, 32'h0,        1'b0, 1'b1};
    tbl[3]  = '{1'b0, 5'h04, 32'h0,        32'h9,        1'b0, 1'b1};
    tbl[4]  = '{1'b1, 5'h18, 32'hCAFFE000, 32'h0,        1'b0, 1'b1};
    tbl[5]  = '{1'b1, 5'h08, 32'hCAFFE000, 32'h0,        1'b1, 1'b1};
    tbl[6]  = '{1'b0, 5'h04, 32'h0,        32'hD,        1'b1, 1'b1};
    tbl[7]  = '{1'b0, 5'h08, 32'h0,        32'hCAFFE000, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 5'h08, 32'h12345678, 32'h0,        1'b1, 1'b1};
    tbl[9]  = '{1'b0, 5'h08, 32'h0,        32'h12345678, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 5'h00, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[11] = '{1'b0, 5'h0C, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[12] = '{1'b0, 5'h18, 32'h0,        32'h0,        1'b1, 1'b1};
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) begin
        ahb_write(tbl[i].addr, tbl[i].wdata);
      end else begin
        ahb_read(tbl[i].addr, rd);
        check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      end
      check($sformatf("tbl%0d_pass", i), 32'(test_pass), 32'(tbl[i].exp_pass));
      check($sformatf("tbl%0d_fail", i), 32'(test_fail), 32'(tbl[i].exp_fail));
    end

    // Reset in the middle of a stream clears everything, including sticky flags.
    for (int i = 0; i < 3; i++) ahb_write(5'h00, 32'h31 + 32'(i));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
    check("mid_rst_hreadyout", 32'(hreadyout), 32'h1);
    check("mid_rst_pass", 32'(test_pass), 32'h0);
    check("mid_rst_fail", 32'(test_fail), 32'h0);
    ahb_read(5'h04, rd);
    check("mid_rst_status", rd, 32'h1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
